// File: rtl/sdram_port_arbiter.sv
// Three-port arbiter in front of a single SDRAM controller command port.
// Port 0 (video) has fixed priority, limited by a run counter so the CPU and
// DMA ports cannot be starved. Ports 1 and 2 share round-robin. Only one
// transaction is in flight: IDLE picks a winner, BUSY holds the command until
// the controller acks, DONE pulses the winner's ack for one cycle.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH    = 24,
  parameter int DATA_WIDTH    = 32,
  parameter int VIDEO_MAX_RUN = 4
) (
  input  logic                    clk,
  input  logic                    reset_in,
  input  logic                    p0_req,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  output logic                    p0_ack,
  input  logic                    p1_req,
  input  logic                    p1_wr,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_bytesel,
  output logic                    p1_ack,
  input  logic                    p2_req,
  input  logic                    p2_wr,
  input  logic [ADDR_WIDTH-1:0]   p2_addr,
  input  logic [DATA_WIDTH-1:0]   p2_wdata,
  input  logic [DATA_WIDTH/8-1:0] p2_bytesel,
  output logic                    p2_ack,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ctrl_req,
  output logic                    ctrl_wr,
  output logic [ADDR_WIDTH-1:0]   ctrl_addr,
  output logic [DATA_WIDTH-1:0]   ctrl_wdata,
  output logic [DATA_WIDTH/8-1:0] ctrl_bytesel,
  input  logic                    ctrl_ack,
  input  logic [DATA_WIDTH-1:0]   ctrl_rdata,
  output logic [1:0]              grant,
  output logic                    busy
);

  localparam int BW    = DATA_WIDTH / 8;
  // A zero-length run limit still needs a 1-bit counter to keep widths legal.
  localparam int RUN_W = (VIDEO_MAX_RUN > 0) ? $clog2(VIDEO_MAX_RUN + 1) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(VIDEO_MAX_RUN);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]           bsel_q, bsel_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RUN_W-1:0]        run_q, run_d;
  logic [1:0]              rr_last_q, rr_last_d;

  logic       low_pend;
  logic       vid_block;
  logic [1:0] win;

  // Winner selection: video first unless its run limit is hit while a low port waits.
  always_comb begin
    low_pend  = p1_req | p2_req;
    vid_block = low_pend && (VIDEO_MAX_RUN != 0) && (run_q == RUN_MAX);
    win       = 2'd3;
    if (p0_req && !vid_block)  win = 2'd0;
    else if (p1_req && p2_req) win = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
    else if (p1_req)           win = 2'd1;
    else if (p2_req)           win = 2'd2;
  end

  // Next-state and command latching for the IDLE -> BUSY -> DONE cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    bsel_d    = bsel_q;
    rdata_d   = rdata_q;
    run_d     = run_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req || p2_req) begin
          state_d = BUSY;
          grant_d = win;
          case (win)
            2'd0: begin
              wr_d = 1'b0; addr_d = p0_addr; wdata_d = '0; bsel_d = '1;
            end
            2'd1: begin
              wr_d = p1_wr; addr_d = p1_addr; wdata_d = p1_wdata; bsel_d = p1_bytesel;
            end
            default: begin
              wr_d = p2_wr; addr_d = p2_addr; wdata_d = p2_wdata; bsel_d = p2_bytesel;
            end
          endcase
          if (win == 2'd0) begin
            // Count only video grants that made a low port wait; saturate.
            if (!low_pend)             run_d = '0;
            else if (run_q != RUN_MAX) run_d = run_q + RUN_W'(1);
          end else begin
            run_d     = '0;
            rr_last_d = win;
          end
        end
      end
      BUSY: begin
        if (ctrl_ack) begin
          rdata_d = ctrl_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'd3;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'd3;
      end
    endcase
  end

  // State and latched command registers; reset drops everything at once.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      grant_q   <= 2'd3;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bsel_q    <= '0;
      rdata_q   <= '0;
      run_q     <= '0;
      rr_last_q <= 2'd2;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      bsel_q    <= bsel_d;
      rdata_q   <= rdata_d;
      run_q     <= run_d;
      rr_last_q <= rr_last_d;
    end
  end

  // Outputs decode straight from registers so ctrl_req falls with reset.
  always_comb begin
    ctrl_req     = (state_q == BUSY);
    busy         = (state_q != IDLE);
    p0_ack       = (state_q == DONE) && (grant_q == 2'd0);
    p1_ack       = (state_q == DONE) && (grant_q == 2'd1);
    p2_ack       = (state_q == DONE) && (grant_q == 2'd2);
    grant        = grant_q;
    ctrl_wr      = wr_q;
    ctrl_addr    = addr_q;
    ctrl_wdata   = wdata_q;
    ctrl_bytesel = bsel_q;
    rdata        = rdata_q;
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomised bench for sdram_port_arbiter: the bench plays all three
// requesters and the SDRAM controller, and a transaction-level model predicts
// winner, command fields, ack timing and returned data from the arbitration rules.
module tb_sdram_port_arbiter;

  localparam int VMAX = 4;

  logic clk = 1'b0;
  logic reset_in;
  always #5 clk = ~clk;

  // main DUT (VIDEO_MAX_RUN=4)
  logic        p0_req, p1_req, p2_req, p1_wr, p2_wr;
  logic [23:0] p0_addr, p1_addr, p2_addr;
  logic [31:0] p1_wdata, p2_wdata;
  logic [3:0]  p1_bytesel, p2_bytesel;
  logic        p0_ack, p1_ack, p2_ack;
  logic [31:0] rdata;
  logic        ctrl_req, ctrl_wr, ctrl_ack;
  logic [23:0] ctrl_addr;
  logic [31:0] ctrl_wdata, ctrl_rdata;
  logic [3:0]  ctrl_bytesel;
  logic [1:0]  grant;
  logic        busy;

  // bench-side requester state
  logic        br_req [3];
  logic [23:0] br_addr[3];
  logic        br_wr  [3];
  logic [31:0] br_wd  [3];
  logic [3:0]  br_bs  [3];

  assign p0_req = br_req[0];  assign p0_addr = br_addr[0];
  assign p1_req = br_req[1];  assign p1_addr = br_addr[1];
  assign p1_wr  = br_wr[1];   assign p1_wdata = br_wd[1];  assign p1_bytesel = br_bs[1];
  assign p2_req = br_req[2];  assign p2_addr = br_addr[2];
  assign p2_wr  = br_wr[2];   assign p2_wdata = br_wd[2];  assign p2_bytesel = br_bs[2];

  sdram_port_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .VIDEO_MAX_RUN(VMAX)) dut (
    .clk(clk), .reset_in(reset_in),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_bytesel(p1_bytesel), .p1_ack(p1_ack),
    .p2_req(p2_req), .p2_wr(p2_wr), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_bytesel(p2_bytesel), .p2_ack(p2_ack),
    .rdata(rdata), .ctrl_req(ctrl_req), .ctrl_wr(ctrl_wr), .ctrl_addr(ctrl_addr),
    .ctrl_wdata(ctrl_wdata), .ctrl_bytesel(ctrl_bytesel), .ctrl_ack(ctrl_ack),
    .ctrl_rdata(ctrl_rdata), .grant(grant), .busy(busy)
  );

  // second DUT with pure fixed priority
  logic        b_p0_req, b_p1_req, b_p2_req, b_p0_ack, b_p1_ack, b_p2_ack;
  logic [31:0] b_rdata, b_ctrl_wdata;
  logic        b_ctrl_req, b_ctrl_wr, b_ctrl_ack, b_busy;
  logic [23:0] b_ctrl_addr;
  logic [3:0]  b_ctrl_bytesel;
  logic [1:0]  b_grant;

  sdram_port_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(32), .VIDEO_MAX_RUN(0)) dut_b (
    .clk(clk), .reset_in(reset_in),
    .p0_req(b_p0_req), .p0_addr(24'h000040), .p0_ack(b_p0_ack),
    .p1_req(b_p1_req), .p1_wr(1'b1), .p1_addr(24'h000080), .p1_wdata(32'h0000_0001),
    .p1_bytesel(4'hF), .p1_ack(b_p1_ack),
    .p2_req(b_p2_req), .p2_wr(1'b0), .p2_addr(24'h0), .p2_wdata(32'h0),
    .p2_bytesel(4'h0), .p2_ack(b_p2_ack),
    .rdata(b_rdata), .ctrl_req(b_ctrl_req), .ctrl_wr(b_ctrl_wr), .ctrl_addr(b_ctrl_addr),
    .ctrl_wdata(b_ctrl_wdata), .ctrl_bytesel(b_ctrl_bytesel), .ctrl_ack(b_ctrl_ack),
    .ctrl_rdata(32'h5555_AAAA), .grant(b_grant), .busy(b_busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // model: phase 0 idle / 1 command out / 2 ack pulse
  int          m_ph, m_w, m_run, m_last, lat_cnt, lat_fix, lat_max, raise_pct;
  bit          m_first, spur_en, rd_fix_en;
  logic [2:0]  raise_mask;
  logic [31:0] m_rdata, rd_fix, last_rdata;
  logic        snap_wr;
  logic [3:0]  snap_bs;
  logic [31:0] snap_wd;
  int          ack_cnt[3];
  int          gq[$];
  int          exp3[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 2};
  int          exp4[4]  = '{1, 2, 1, 2};

  task automatic check_outputs();
    chk("busy",     busy,     m_ph != 0);
    chk("ctrl_req", ctrl_req, m_ph == 1);
    chk("grant",    grant,    (m_ph == 0) ? 3 : m_w);
    chk("p0_ack",   p0_ack,   m_ph == 2 && m_w == 0);
    chk("p1_ack",   p1_ack,   m_ph == 2 && m_w == 1);
    chk("p2_ack",   p2_ack,   m_ph == 2 && m_w == 2);
    if (m_ph == 1) begin
      chk("ctrl_addr",  ctrl_addr,    br_addr[m_w]);
      chk("ctrl_wr",    ctrl_wr,      (m_w == 0) ? 1'b0 : br_wr[m_w]);
      chk("ctrl_wdata", ctrl_wdata,   (m_w == 0) ? 32'h0 : br_wd[m_w]);
      chk("ctrl_bsel",  ctrl_bytesel, (m_w == 0) ? 4'hF : br_bs[m_w]);
      if (m_first) begin
        gq.push_back(int'(grant));
        snap_wr = ctrl_wr; snap_bs = ctrl_bytesel; snap_wd = ctrl_wdata;
        m_first = 0;
      end
    end
    if (m_ph == 2) begin
      chk("rdata", rdata, m_rdata);
      last_rdata = rdata;
    end
    if (p0_ack) ack_cnt[0]++;
    if (p1_ack) ack_cnt[1]++;
    if (p2_ack) ack_cnt[2]++;
  endtask

  task automatic drive();
    if (m_ph == 2) br_req[m_w] = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (!br_req[p] && raise_mask[p] && !(m_ph == 2 && p == m_w) &&
          int'($urandom_range(99, 0)) < raise_pct) begin
        br_req[p] = 1'b1; br_addr[p] = 24'($urandom); br_wr[p] = 1'($urandom);
        br_wd[p]  = $urandom; br_bs[p] = 4'($urandom);
      end
    end
    ctrl_ack   = 1'b0;
    ctrl_rdata = $urandom;
    if (m_ph == 1) begin
      if (lat_cnt == 0) begin
        ctrl_ack = 1'b1;
        if (rd_fix_en) ctrl_rdata = rd_fix;
        m_rdata = ctrl_rdata;
      end else lat_cnt--;
    end else if (spur_en && $urandom_range(7, 0) == 0) ctrl_ack = 1'b1;
  endtask

  // predict what the next clock edge does, from the rules of arbitration
  task automatic advance();
    bit low;
    case (m_ph)
      0: if (br_req[0] || br_req[1] || br_req[2]) begin
           low = br_req[1] || br_req[2];
           if (br_req[0] && !(low && m_run >= VMAX)) begin
             m_w   = 0;
             m_run = low ? ((m_run < VMAX) ? m_run + 1 : m_run) : 0;
           end else begin
             m_w    = (br_req[1] && br_req[2]) ? ((m_last == 1) ? 2 : 1) : (br_req[1] ? 1 : 2);
             m_last = m_w;
             m_run  = 0;
           end
           m_ph    = 1;
           m_first = 1;
           lat_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max, 0));
         end
      1: if (ctrl_ack) m_ph = 2;
      default: m_ph = 0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    drive();
    advance();
  endtask

  task automatic model_reset();
    m_ph = 0; m_run = 0; m_last = 2; m_first = 0;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    for (int p = 0; p < 3; p++) br_req[p] = 1'b0;
    ctrl_ack = 1'b0;
    b_ctrl_ack = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 3);        chk("rst_ctrl_req", ctrl_req, 0);
    chk("rst_busy", busy, 0);          chk("rst_acks", {p0_ack, p1_ack, p2_ack}, 0);
    chk("rst_addr", ctrl_addr, 0);     chk("rst_wr", ctrl_wr, 0);
    chk("rst_wdata", ctrl_wdata, 0);   chk("rst_bsel", ctrl_bytesel, 0);
    chk("rst_rdata", rdata, 0);
    reset_in = 1'b1;
    advance();
  endtask

  task automatic finish_txn();
    int k = 0;
    do begin step(); k++; end while (m_ph != 0 && k < 200);
  endtask

  initial begin
    int k, base, nb;
    reset_in = 1'b0;
    for (int p = 0; p < 3; p++) begin
      br_req[p] = 0; br_addr[p] = 0; br_wr[p] = 0; br_wd[p] = 0; br_bs[p] = 0;
    end
    ctrl_ack = 0; ctrl_rdata = 0;
    b_p0_req = 1'b1; b_p1_req = 1'b1; b_p2_req = 1'b0; b_ctrl_ack = 1'b0;
    raise_mask = 3'b000; raise_pct = 0; lat_fix = -1; lat_max = 4;
    spur_en = 0; rd_fix_en = 0; rd_fix = 0; m_rdata = 0; last_rdata = 0;
    ack_cnt[0] = 0; ack_cnt[1] = 0; ack_cnt[2] = 0;

    // single CPU read
    do_reset();
    br_req[1] = 1; br_addr[1] = 24'h000100; br_wr[1] = 0; br_bs[1] = 4'hF; br_wd[1] = 0;
    lat_fix = 4; rd_fix_en = 1; rd_fix = 32'hDEADBEEF;
    advance();
    finish_txn();
    chk("t1_rdata", last_rdata, 32'hDEADBEEF);
    step();

    // CPU write, fields held through BUSY
    br_req[1] = 1; br_addr[1] = 24'h00ABCD; br_wr[1] = 1; br_bs[1] = 4'b0011;
    br_wd[1] = 32'h12345678; lat_fix = 3; rd_fix_en = 0;
    advance();
    finish_txn();
    chk("t2_wr", snap_wr, 1); chk("t2_bsel", snap_bs, 4'b0011); chk("t2_wdata", snap_wd, 32'h12345678);

    // all three held: video run of four, then alternating low ports
    do_reset();
    gq.delete(); raise_mask = 3'b111; raise_pct = 100; lat_fix = -1; lat_max = 2;
    k = 0;
    while (gq.size() < 10 && k < 400) begin step(); k++; end
    for (int i = 0; i < 10; i++) chk("t3_order", (gq.size() > i) ? gq[i] : 99, exp3[i]);

    // ports 1 and 2 only: alternate, port 1 first
    do_reset();
    gq.delete(); raise_mask = 3'b110;
    k = 0;
    while (gq.size() < 4 && k < 200) begin step(); k++; end
    for (int i = 0; i < 4; i++) chk("t4_order", (gq.size() > i) ? gq[i] : 99, exp4[i]);

    // reset during a port-2 transaction
    do_reset();
    raise_mask = 3'b100; lat_fix = 20;
    k = 0;
    while (m_ph != 1 && k < 50) begin step(); k++; end
    step(); step();
    reset_in = 1'b0; ctrl_ack = 1'b0;
    #1;
    chk("t6_ctrl_req", ctrl_req, 0); chk("t6_grant", grant, 3);
    chk("t6_busy", busy, 0);         chk("t6_p2_ack", p2_ack, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_hold_ack", p2_ack, 0); chk("t6_hold_req", ctrl_req, 0);
    end
    model_reset();
    raise_mask = 3'b000; lat_fix = 2;
    base = ack_cnt[2];
    reset_in = 1'b1;
    advance();
    finish_txn();
    step();
    chk("t6_served", ack_cnt[2] - base, 1);

    // random traffic with stray controller acks
    do_reset();
    raise_mask = 3'b111; raise_pct = 30; lat_fix = -1; lat_max = 4; spur_en = 1;
    for (int i = 0; i < 1500; i++) step();
    chk("rand_p1_progress", ack_cnt[1] > 20, 1);
    chk("rand_p2_progress", ack_cnt[2] > 20, 1);

    // pure fixed priority: video always wins, CPU waits
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_ctrl_req) chk("t5_grant", b_grant, 0);
      chk("t5_p1_ack", b_p1_ack, 0);
      if (b_p0_ack) nb++;
      b_ctrl_ack = b_ctrl_req;
    end
    chk("t5_progress", nb >= 10, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
